// File: rtl/simple_ser_tx.sv
// simple_ser_tx: byte-in, async-frame-out serial transmitter (start, LSB-first data, optional even parity, stop)
//
// Parameters:
//   DW   data width in bits (1..16)
//   DIV  clock cycles per serial bit (1..65535)
// Ports:
//   clk     in   clock, rising edge
//   resetn  in   asynchronous active-low reset
//   d_in    in   [DW] parallel data, captured on the acceptance edge (d_vld && d_rdy)
//   d_vld   in   d_in valid
//   d_rdy   out  ready to accept, high only while idle
//   s_out   out  serial line, idles high
//   busy    out  frame in progress
// Build option:
//   SIMPLE_SER_TX_PARITY_EN  adds an even-parity bit between the data bits and the stop bit
module simple_ser_tx #(
    parameter int DW  = 8,
    parameter int DIV = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] d_in,
    input  logic          d_vld,
    output logic          d_rdy,
    output logic          s_out,
    output logic          busy
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
    localparam logic [CW-1:0] CMAX = CW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
`ifdef SIMPLE_SER_TX_PARITY_EN
        , PAR = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic          wrap;
`ifdef SIMPLE_SER_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // With DIV=1 TMAX is 0 and the timer never leaves 0, so every cycle ends a bit.
    assign wrap = (timer_q == TMAX);

    always_comb begin
        state_d = state_q;
        timer_d = wrap ? '0 : timer_q + TW'(1);
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
`ifdef SIMPLE_SER_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (d_vld) begin
                    state_d = START;
                    shreg_d = d_in;
                    bcnt_d  = '0;
`ifdef SIMPLE_SER_TX_PARITY_EN
                    par_d   = ^d_in;
`endif
                end
            end
            START: state_d = wrap ? DATA : START;
            DATA: begin
                if (wrap) begin
                    shreg_d = shreg_q >> 1;
                    bcnt_d  = (bcnt_q == CMAX) ? '0 : bcnt_q + CW'(1);
`ifdef SIMPLE_SER_TX_PARITY_EN
                    state_d = (bcnt_q == CMAX) ? PAR : DATA;
`else
                    state_d = (bcnt_q == CMAX) ? STOP : DATA;
`endif
                end
            end
`ifdef SIMPLE_SER_TX_PARITY_EN
            PAR:  state_d = wrap ? STOP : PAR;
`endif
            STOP: state_d = wrap ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            timer_q <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
`ifdef SIMPLE_SER_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
`ifdef SIMPLE_SER_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs decode registered state only, so reset forces the line high at once.
    assign d_rdy = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
`ifdef SIMPLE_SER_TX_PARITY_EN
    assign s_out = (state_q == START) ? 1'b0 :
                   (state_q == DATA)  ? shreg_q[0] :
                   (state_q == PAR)   ? par_q : 1'b1;
`else
    assign s_out = (state_q == START) ? 1'b0 :
                   (state_q == DATA)  ? shreg_q[0] : 1'b1;
`endif
endmodule
